// File: rtl/irq_arbiter.sv
// irq_arbiter: IF/IE interrupt flags, fixed-priority arbiter and
// IM2-style vectored acknowledge FSM.
// Ports: clock, reset_n (async, active-low); cs/A/Di/Do/rd_n/wr_n
// register bus; m1_n/iorq_n CPU acknowledge cycle; int_req/int_ack
// per-source request and ack pulse; int_n to CPU; jump_addr vector.
module irq_arbiter #(
  parameter int                 NUM_SRC    = 5,
  parameter logic [7:0]         VEC_BASE   = 8'h40,
  parameter logic [7:0]         VEC_STRIDE = 8'd8,
  parameter logic [NUM_SRC-1:0] LEVEL_MASK = '0,
  parameter logic [15:0]        IF_ADDR    = 16'hFF0F,
  parameter logic [15:0]        IE_ADDR    = 16'hFFFF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cs,
  input  logic [15:0]        A,
  input  logic [7:0]         Di,
  output logic [7:0]         Do,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               m1_n,
  input  logic               iorq_n,
  input  logic [NUM_SRC-1:0] int_req,
  output logic [NUM_SRC-1:0] int_ack,
  output logic               int_n,
  output logic [7:0]         jump_addr
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SRC-1:0] if_q, ie_q, prev_q;
  logic [NUM_SRC-1:0] set_v, clr_v;
  logic [NUM_SRC-1:0] if_base, if_d;
  logic [NUM_SRC-1:0] pending;
  logic               armed_q;
  logic [2:0]         win_idx, idx_q;
  logic               win_vld, vld_q;
  logic               wr_if, wr_ie;
  logic               ack_end;
  logic [7:0]         rd_if, rd_ie;
  logic               unused_di;

  assign unused_di = ^Di;

  function automatic logic [7:0] vec(input logic [2:0] i);
    return VEC_BASE + {5'b0, i} * VEC_STRIDE;
  endfunction

  assign wr_if   = cs & ~wr_n & (A == IF_ADDR);
  assign wr_ie   = cs & ~wr_n & (A == IE_ADDR);
  assign pending = if_q & ie_q;

  // armed_q masks edge detection on the first clock after reset so a
  // request already high at release is not mistaken for a new edge.
  assign set_v = int_req &
    (LEVEL_MASK | (~prev_q & {NUM_SRC{armed_q}}));

  assign ack_end = (state_q == ACK) & (m1_n | iorq_n) & vld_q;

  always_comb begin
    clr_v = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_v[i] = ack_end & (idx_q == 3'(i));
    end
  end

  // Set beats both CPU write and acknowledge clear.
  assign if_base = wr_if ? Di[NUM_SRC-1:0] : if_q;
  assign if_d    = (if_base & ~clr_v) | set_v;

  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_idx = 3'(i);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (~m1_n & ~iorq_n) state_d = ACK;
      ACK:  if (m1_n | iorq_n) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_q    <= '0;
      ie_q    <= '0;
      prev_q  <= '0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      int_n   <= 1'b1;
      int_ack <= '0;
    end else begin
      if_q    <= if_d;
      prev_q  <= int_req;
      armed_q <= 1'b1;
      state_q <= state_d;
      if (wr_ie) ie_q <= Di[NUM_SRC-1:0];
      if (state_q == IDLE && state_d == ACK) begin
        idx_q <= win_idx;
        vld_q <= win_vld;
      end
      int_n   <= (state_d == IDLE) ? ~|pending : 1'b1;
      int_ack <= clr_v;
    end
  end

  always_comb begin
    jump_addr = 8'hFF;
    unique case (state_q)
      IDLE: if (win_vld) jump_addr = vec(win_idx);
      ACK:  if (vld_q) jump_addr = vec(idx_q);
      default: jump_addr = 8'hFF;
    endcase
  end

  always_comb begin
    rd_if = 8'hFF;
    rd_if[NUM_SRC-1:0] = if_q;
    rd_ie = 8'h00;
    rd_ie[NUM_SRC-1:0] = ie_q;
    Do = 8'hFF;
    if (cs & ~rd_n) begin
      if (A == IF_ADDR)      Do = rd_if;
      else if (A == IE_ADDR) Do = rd_ie;
    end
  end

endmodule
